// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: expands one 512-bit block into W_0..W_63 with K_t via a 16-word sliding window.
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] blk_i,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic [31:0]  w_o,
  output logic [31:0]  k_o,
  output logic [5:0]   t_o,
  output logic         last_o,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  state_t      state_q, state_d;
  logic        blk_ready_q, blk_ready_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    if (state_q == IDLE && blk_valid && blk_ready_q) begin
      for (int i = 0; i < 16; i++) w_d[i] = blk_i[32*(15-i) +: 32];
      t_d     = '0;
      state_d = RUN;
    end else if (state_q == RUN && out_ready) begin
      if (t_q == 6'd63) begin
        state_d = IDLE;
        t_d     = '0;
      end else begin
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
        t_d     = t_q + 6'd1;
      end
    end
    blk_ready_d = (state_d == IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_ready_q <= 1'b0;
      t_q         <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      blk_ready_q <= blk_ready_d;
      t_q         <= t_d;
      w_q         <= w_d;
    end
  end
  // Outputs are masked outside RUN so the ROM never shows K_0 while idle.
  assign out_valid = (state_q == RUN);
  assign blk_ready = blk_ready_q;
  assign w_o       = out_valid ? w_q[0] : '0;
  assign k_o       = out_valid ? K[t_q] : '0;
  assign t_o       = t_q;
  assign last_o    = out_valid && (t_q == 6'd63);
endmodule

// File: doc/sha256_msg_schedule.md
# sha256_msg_schedule

SHA-256 message schedule and round-constant source. It accepts one 512-bit padded message block and emits the 64 schedule words W_t, each paired with its round constant K_t, one word per handshake. It sits directly upstream of the round stage and drives that stage's W_t, K_t and in_valid inputs from w_o, k_o and out_valid. A 16-word sliding window expands the schedule on the fly; no 64-word store is used.

## Interface
- No parameters; word width is fixed at 32 and round count at 64.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  asynchronous, active-high reset.
- blk_i  in  512  padded message block; word j = blk_i[511-32j -: 32], so W0 is in the MSBs (big-endian).
- blk_valid  in  1  blk_i is valid.
- blk_ready  out  1  block can be accepted; high only in IDLE.
- w_o  out  32  schedule word W_t.
- k_o  out  32  round constant K_t.
- t_o  out  6  round index t of the current output.
- last_o  out  1  high when t_o == 63 and out_valid is high.
- out_valid  out  1  w_o, k_o, t_o and last_o are valid.
- out_ready  in  1  downstream accepts the current word.

## Operation
- States:
  - IDLE: blk_ready = 1, out_valid = 0.
  - RUN: blk_ready = 0, out_valid = 1.
- IDLE -> RUN when blk_valid && blk_ready. On that edge:
  - window w[0..15] is loaded with block words 0..15.
  - t is set to 0.
- In RUN, window invariant: w[i] = W_{t+i}; w_o = w[0]; k_o = K[t] from an internal 64-entry FIPS 180-4 constant ROM.
- Advance on each out_valid && out_ready with t < 63:
  - w[i] <= w[i+1] for i = 0..14.
  - w[15] <= sig1(w[14]) + w[9] + sig0(w[1]) + w[0], modulo 2^32, carries discarded.
  - t <= t + 1.
- sig0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- sig1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Words generated past W63 are don't-care and never appear on w_o.
- Handshake with t == 63: RUN -> IDLE; out_valid drops and blk_ready rises on the next cycle.
- blk_valid is ignored in RUN; the block must be held by upstream until blk_ready.
- Backpressure: while out_valid && !out_ready, w_o, k_o, t_o, last_o and all internal state hold.

## Timing
- Reset (async assert, held): out_valid = 0, blk_ready = 0, w_o = 0, k_o = 0, t_o = 0, last_o = 0, state = IDLE, window cleared.
- blk_ready rises on the first clk edge after rst deasserts.
- Latency: block accepted at edge N -> out_valid = 1 with t_o = 0, w_o = W0 from edge N (next cycle).
- Throughput: 1 word per cycle with out_ready held high.
- A block occupies 64 output cycles plus 1 IDLE cycle before the next acceptance, giving a 65-cycle period under no stall.
- All outputs are registered or decoded from registered state; there are no combinational paths from out_ready or blk_valid to any output.
- Reset mid-block: the block is abandoned and out_valid = 0 immediately; no partial continuation after release.

## Test plan
- "abc" padded block (word0 = 0x61626380, words 1..14 = 0, word15 = 0x00000018) with out_ready = 1:
  - t=0: W = 0x61626380, K = 0x428a2f98.
  - t=16: W = 0x61626380.
  - t=17: W = 0x000f0000.
  - t=63: K = 0xc67178f2, last_o = 1.
  - All 64 words match the software model.
- Random out_ready (50% low): W/K sequence identical to the no-stall run; outputs stable through every stall cycle; exactly 64 handshakes per block.
- Back-to-back blocks with blk_valid held high:
  - second block accepted exactly 1 cycle after the t=63 handshake.
  - t_o restarts at 0.
  - blk_ready is 0 for all 64 RUN cycles.
- Block with all words 0xFFFFFFFF: every W_t matches the model, confirming carry discard and rotate/shift wrap at bit 31.
- Assert rst with t_o = 30 during a stall: all outputs go to 0 asynchronously; after release, a fresh "abc" block produces W0 = 0x61626380 with t_o = 0.
- blk_valid pulsed during RUN with a different blk_i: no effect on the current sequence.
